bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Two-master, one-slave arbiter for the shared 64-bit system bus: bus_address, bus_write_data, bus_write_enable, bus_read_enable and bus_read_data.
- Master 0 is the riscv64 core's load/store port. Master 1 is a second bus agent, such as the DMA/debug loader.
- Round-robin grant, single outstanding transaction, fixed slave read latency. Read data is returned to the owning master with a valid pulse.

Parameters:
- READ_LATENCY, 1, cycles from the bus_read_enable-high cycle to the cycle bus_read_data is valid; must be ≥1, max 15.
- IDLE_ADDR, `Ram_base, value driven on bus_address when no transaction is issued.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- m0_address  in  64  master 0 address.
- m0_write_data  in  64  master 0 write data.
- m0_write_enable  in  1  master 0 write request (level).
- m0_read_enable  in  1  master 0 read request (level).
- m0_grant  out  1  one-cycle pulse: master 0 request issued to the bus this cycle.
- m0_read_data  out  64  captured read data for master 0.
- m0_read_valid  out  1  one-cycle pulse: m0_read_data updated.
- m1_address, m1_write_data, m1_write_enable, m1_read_enable, m1_grant, m1_read_data, m1_read_valid: same as master 0, for master 1.
- bus_address  out  64  slave address.
- bus_write_data  out  64  slave write data.
- bus_write_enable  out  1  slave write strobe (one cycle per write).
- bus_read_enable  out  1  slave read strobe (one cycle per read).
- bus_read_data  in  64  slave read data.
- busy  out  1  high while in RWAIT.

Behaviour:
- **Reset (async, reset=0).**
  - All outputs 0, except bus_address = IDLE_ADDR.
  - State = IDLE, last_owner = 1 (master 0 wins the first tie), latency counter = 0.
  - An in-flight read is dropped; no read_valid is produced for it.
- **Request definitions.**
  - reqX = mX_write_enable | mX_read_enable, masked to 0 in any cycle where mX_grant = 1. A master deasserts the cycle after it sees its grant, and the mask prevents double issue.
  - If both enables of one master are high, the request is a write; the read is ignored.
- **FSM states.**
  - IDLE: bus free.
  - RWAIT: read outstanding.
- **IDLE, no request.** At the clock edge: bus_address <= IDLE_ADDR; bus_write_data <= 0; bus_write_enable <= 0; bus_read_enable <= 0.
- **IDLE, request present.**
  - Selection: if only one reqX, that master. If both, the master ≠ last_owner.
  - At the edge:
    - bus_address, bus_write_data (write only, else 0) and the strobe register from the selected master.
    - mX_grant <= 1; owner <= X; last_owner <= X.
  - Write: stay in IDLE. The write strobe is visible exactly one cycle (N+1). A new grant can issue at the end of N+1, so the bus can accept one write per cycle with the masters alternating.
  - Read: state <= RWAIT; cnt <= READ_LATENCY.
- **RWAIT.**
  - bus outputs return to idle values at the first edge; the read strobe is one cycle only.
  - No grants are issued; requests wait.
  - Each cycle: if cnt ≠ 0, cnt <= cnt − 1.
  - In the cycle cnt == 0 (cycle N+1+READ_LATENCY): m_owner_read_data <= bus_read_data, m_owner_read_valid <= 1, state <= IDLE.
- **Latency.**
  - Write: request seen in cycle N; grant and bus strobe in N+1.
  - Read: grant and strobe in N+1; read_valid in N+2+READ_LATENCY. For READ_LATENCY = 1, read_valid is in N+3.
- **Read-data hold.** mX_read_data holds its value between captures. The other master's read_data is never touched.
- **grant/read_valid.** Each is exactly one cycle wide and deasserts at the next edge unconditionally.
- **Starvation.** Not possible: with continuous requests from both masters, grants strictly alternate.

Test Plan:
1. **Reset and first tie.** Reset low for 3 cycles with both masters requesting writes (m0 addr 0x100/data 0xAA, m1 addr 0x200/data 0xBB) -> all outputs 0 and bus_address = IDLE_ADDR during reset. After release: m0 grants first; bus shows 0x100/0xAA with write_enable for exactly one cycle; the next issue is m1 0x200/0xBB.
2. **Single read, READ_LATENCY = 1.** m0 reads 0x80, slave returns 0xDEADBEEF in the cycle after the strobe -> m0_read_valid is high exactly one cycle at N+3 with m0_read_data = 0xDEADBEEF; busy is high for two cycles; m1_read_data stays 0.
3. **Request during RWAIT.** m0 read in flight; m1 requests a write mid-wait -> no m1_grant until state returns to IDLE. The m1 write then issues the cycle after m0_read_valid's capture edge.
4. **Sustained contention.** Both masters hold write requests for 8 cycles (each deasserts for one cycle after its grant, then reasserts) -> grants alternate m0, m1, m0, …; no master is granted twice in a row.
5. **READ_LATENCY = 3, reset mid-read.** m1 reads; assert reset in the second RWAIT cycle -> m1_read_valid never pulses; state returns to IDLE; after release m0 (last_owner = 1) wins the next tie.
6. **Read+write from the same master.** m0 asserts both enables (addr 0x40, data 0x55) -> a bus write is issued, bus_read_enable stays 0, and no read_valid pulse occurs.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter for the shared 64-bit system bus.
// Only one transaction is in flight at a time. A read holds the bus for a fixed
// slave latency, and the returned data is steered back to the master that issued it.
module bus_arbiter #(
    parameter int unsigned READ_LATENCY = 1,                      // legal range 1..15
    parameter logic [63:0] IDLE_ADDR    = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [63:0] m0_address,
    input  logic [63:0] m0_write_data,
    input  logic        m0_write_enable,
    input  logic        m0_read_enable,
    output logic        m0_grant,
    output logic [63:0] m0_read_data,
    output logic        m0_read_valid,

    input  logic [63:0] m1_address,
    input  logic [63:0] m1_write_data,
    input  logic        m1_write_enable,
    input  logic        m1_read_enable,
    output logic        m1_grant,
    output logic [63:0] m1_read_data,
    output logic        m1_read_valid,

    output logic [63:0] bus_address,
    output logic [63:0] bus_write_data,
    output logic        bus_write_enable,
    output logic        bus_read_enable,
    input  logic [63:0] bus_read_data,
    output logic        busy
);

    typedef enum logic {IDLE, RWAIT} state_t;

    state_t      state;
    logic        last_owner;   // master granted most recently; loses the next tie
    logic        owner;        // master whose read is outstanding
    logic [3:0]  cnt;          // cycles left before read data is captured

    logic        req0;
    logic        req1;
    logic        sel;
    logic        sel_write;
    logic [63:0] sel_address;
    logic [63:0] sel_write_data;

    // Requests are masked in the grant cycle so a master that is still holding
    // its enable (it only sees the grant now) cannot be issued twice.
    always_comb begin
        req0 = (m0_write_enable | m0_read_enable) & ~m0_grant;
        req1 = (m1_write_enable | m1_read_enable) & ~m1_grant;
        if (req0 && req1) begin
            sel = ~last_owner;
        end else begin
            sel = req1;
        end
        sel_write      = sel ? m1_write_enable : m0_write_enable;
        sel_address    = sel ? m1_address      : m0_address;
        sel_write_data = sel ? m1_write_data   : m0_write_data;
    end

    // Arbitration FSM; every output is registered here. A read that is in flight
    // when reset asserts is abandoned without a read_valid pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            last_owner       <= 1'b1;
            owner            <= 1'b0;
            cnt              <= 4'd0;
            busy             <= 1'b0;
            m0_grant         <= 1'b0;
            m1_grant         <= 1'b0;
            m0_read_valid    <= 1'b0;
            m1_read_valid    <= 1'b0;
            m0_read_data     <= 64'd0;
            m1_read_data     <= 64'd0;
            bus_address      <= IDLE_ADDR;
            bus_write_data   <= 64'd0;
            bus_write_enable <= 1'b0;
            bus_read_enable  <= 1'b0;
        end else begin
            // grant and read_valid are single-cycle pulses
            m0_grant      <= 1'b0;
            m1_grant      <= 1'b0;
            m0_read_valid <= 1'b0;
            m1_read_valid <= 1'b0;

            // bus idles unless a new transaction is issued below
            bus_address      <= IDLE_ADDR;
            bus_write_data   <= 64'd0;
            bus_write_enable <= 1'b0;
            bus_read_enable  <= 1'b0;

            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        bus_address      <= sel_address;
                        bus_write_data   <= sel_write ? sel_write_data : 64'd0;
                        bus_write_enable <= sel_write;
                        bus_read_enable  <= ~sel_write;
                        m0_grant         <= ~sel;
                        m1_grant         <= sel;
                        owner            <= sel;
                        last_owner       <= sel;
                        if (!sel_write) begin
                            state <= RWAIT;
                            cnt   <= 4'(READ_LATENCY);
                            busy  <= 1'b1;
                        end
                    end
                end

                RWAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (owner) begin
                            m1_read_data  <= bus_read_data;
                            m1_read_valid <= 1'b1;
                        end else begin
                            m0_read_data  <= bus_read_data;
                            m0_read_valid <= 1'b1;
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: drives two arbiters (read latency 1 and 3) from the same
// master/slave stimulus and checks both against a cycle-scheduled reference
// model, plus directed sequences with hand-computed expectations.
module tb_bus_arbiter;

    localparam logic [63:0] IDLE = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] m0_address, m0_write_data, m1_address, m1_write_data;
    logic        m0_write_enable, m0_read_enable, m1_write_enable, m1_read_enable;
    logic [63:0] bus_read_data;

    logic        a_m0_grant, a_m1_grant, a_m0_read_valid, a_m1_read_valid;
    logic [63:0] a_m0_read_data, a_m1_read_data, a_bus_address, a_bus_write_data;
    logic        a_bus_write_enable, a_bus_read_enable, a_busy;
    logic        b_m0_grant, b_m1_grant, b_m0_read_valid, b_m1_read_valid;
    logic [63:0] b_m0_read_data, b_m1_read_data, b_bus_address, b_bus_write_data;
    logic        b_bus_write_enable, b_bus_read_enable, b_busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.READ_LATENCY(1), .IDLE_ADDR(IDLE)) dut_a (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_write_data(m0_write_data),
        .m0_write_enable(m0_write_enable), .m0_read_enable(m0_read_enable),
        .m0_grant(a_m0_grant), .m0_read_data(a_m0_read_data), .m0_read_valid(a_m0_read_valid),
        .m1_address(m1_address), .m1_write_data(m1_write_data),
        .m1_write_enable(m1_write_enable), .m1_read_enable(m1_read_enable),
        .m1_grant(a_m1_grant), .m1_read_data(a_m1_read_data), .m1_read_valid(a_m1_read_valid),
        .bus_address(a_bus_address), .bus_write_data(a_bus_write_data),
        .bus_write_enable(a_bus_write_enable), .bus_read_enable(a_bus_read_enable),
        .bus_read_data(bus_read_data), .busy(a_busy)
    );

    bus_arbiter #(.READ_LATENCY(3), .IDLE_ADDR(IDLE)) dut_b (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_write_data(m0_write_data),
        .m0_write_enable(m0_write_enable), .m0_read_enable(m0_read_enable),
        .m0_grant(b_m0_grant), .m0_read_data(b_m0_read_data), .m0_read_valid(b_m0_read_valid),
        .m1_address(m1_address), .m1_write_data(m1_write_data),
        .m1_write_enable(m1_write_enable), .m1_read_enable(m1_read_enable),
        .m1_grant(b_m1_grant), .m1_read_data(b_m1_read_data), .m1_read_valid(b_m1_read_valid),
        .bus_address(b_bus_address), .bus_write_data(b_bus_write_data),
        .bus_write_enable(b_bus_write_enable), .bus_read_enable(b_bus_read_enable),
        .bus_read_data(bus_read_data), .busy(b_busy)
    );

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model (index 0 = latency 1, 1 = latency 3) ----------------
    int          k = 0;                 // edge counter
    logic [63:0] e_addr [2] = '{IDLE, IDLE};
    logic [63:0] e_wd   [2] = '{64'd0, 64'd0};
    logic        e_we   [2] = '{1'b0, 1'b0};
    logic        e_re   [2] = '{1'b0, 1'b0};
    logic        e_busy [2] = '{1'b0, 1'b0};
    logic        e_g    [2][2];
    logic        e_rv   [2][2];
    logic [63:0] e_rd   [2][2];
    logic        e_last [2] = '{1'b1, 1'b1};
    logic        e_own  [2] = '{1'b0, 1'b0};
    logic        pending[2] = '{1'b0, 1'b0};
    int          cap_edge[2] = '{0, 0};

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic model_reset(input int i);
        e_addr[i] = IDLE; e_wd[i] = 64'd0; e_we[i] = 1'b0; e_re[i] = 1'b0;
        e_busy[i] = 1'b0; e_last[i] = 1'b1; pending[i] = 1'b0;
        for (int m = 0; m < 2; m++) begin
            e_g[i][m] = 1'b0; e_rv[i][m] = 1'b0; e_rd[i][m] = 64'd0;
        end
    endtask

    // A read issued at edge t owns the bus until its capture at edge t+latency+1.
    task automatic model_step(input int i);
        logic r0, r1, pick, wr;
        r0 = (m0_write_enable | m0_read_enable) & ~e_g[i][0];
        r1 = (m1_write_enable | m1_read_enable) & ~e_g[i][1];
        for (int m = 0; m < 2; m++) begin
            e_g[i][m] = 1'b0; e_rv[i][m] = 1'b0;
        end
        e_addr[i] = IDLE; e_wd[i] = 64'd0; e_we[i] = 1'b0; e_re[i] = 1'b0;
        if (pending[i]) begin
            if (k == cap_edge[i]) begin
                e_rd[i][e_own[i]] = bus_read_data;
                e_rv[i][e_own[i]] = 1'b1;
                pending[i] = 1'b0;
            end
        end else if (r0 | r1) begin
            pick = (r0 & r1) ? ~e_last[i] : r1;
            wr   = pick ? m1_write_enable : m0_write_enable;
            e_addr[i] = pick ? m1_address : m0_address;
            e_wd[i]   = wr ? (pick ? m1_write_data : m0_write_data) : 64'd0;
            e_we[i]   = wr;
            e_re[i]   = ~wr;
            e_g[i][pick] = 1'b1;
            e_last[i] = pick;
            e_own[i]  = pick;
            if (!wr) begin
                pending[i]  = 1'b1;
                cap_edge[i] = k + lat(i) + 1;
            end
        end
        e_busy[i] = pending[i];
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            model_reset(0);
            model_reset(1);
        end else begin
            k++;
            model_step(0);
            model_step(1);
        end
    end

    task automatic cmp_inst(input int i, input string t,
                            input logic [63:0] addr, input logic [63:0] wd,
                            input logic we, input logic re, input logic bsy,
                            input logic g0, input logic g1, input logic rv0, input logic rv1,
                            input logic [63:0] rd0, input logic [63:0] rd1);
        chk64($sformatf("%s_bus_address", t), addr, e_addr[i]);
        chk64($sformatf("%s_bus_write_data", t), wd, e_wd[i]);
        chk1($sformatf("%s_bus_write_enable", t), we, e_we[i]);
        chk1($sformatf("%s_bus_read_enable", t), re, e_re[i]);
        chk1($sformatf("%s_busy", t), bsy, e_busy[i]);
        chk1($sformatf("%s_m0_grant", t), g0, e_g[i][0]);
        chk1($sformatf("%s_m1_grant", t), g1, e_g[i][1]);
        chk1($sformatf("%s_m0_read_valid", t), rv0, e_rv[i][0]);
        chk1($sformatf("%s_m1_read_valid", t), rv1, e_rv[i][1]);
        chk64($sformatf("%s_m0_read_data", t), rd0, e_rd[i][0]);
        chk64($sformatf("%s_m1_read_data", t), rd1, e_rd[i][1]);
    endtask

    // Every cycle: both DUTs against the model
    always @(negedge clk) begin
        cmp_inst(0, "lat1", a_bus_address, a_bus_write_data, a_bus_write_enable,
                 a_bus_read_enable, a_busy, a_m0_grant, a_m1_grant,
                 a_m0_read_valid, a_m1_read_valid, a_m0_read_data, a_m1_read_data);
        cmp_inst(1, "lat3", b_bus_address, b_bus_write_data, b_bus_write_enable,
                 b_bus_read_enable, b_busy, b_m0_grant, b_m1_grant,
                 b_m0_read_valid, b_m1_read_valid, b_m0_read_data, b_m1_read_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        m0_write_enable = 1'b1; m0_read_enable = 1'b0; m0_address = 64'h100; m0_write_data = 64'hAA;
        m1_write_enable = 1'b1; m1_read_enable = 1'b0; m1_address = 64'h200; m1_write_data = 64'hBB;
        bus_read_data = 64'd0;

        // Reset with both masters requesting, then the first tie goes to m0
        repeat (3) tick();
        chk64("t1_rst_bus_address", a_bus_address, IDLE);
        chk1("t1_rst_write_enable", a_bus_write_enable, 1'b0);
        chk1("t1_rst_m0_grant", a_m0_grant, 1'b0);
        chk64("t1_rst_b_bus_address", b_bus_address, IDLE);
        reset = 1'b1;
        tick();
        chk1("t1_m0_grant", a_m0_grant, 1'b1);
        chk1("t1_m1_grant_low", a_m1_grant, 1'b0);
        chk64("t1_addr_m0", a_bus_address, 64'h100);
        chk64("t1_data_m0", a_bus_write_data, 64'hAA);
        chk1("t1_we_m0", a_bus_write_enable, 1'b1);
        m0_write_enable = 1'b0;
        tick();
        chk1("t1_m1_grant", a_m1_grant, 1'b1);
        chk1("t1_m0_grant_low", a_m0_grant, 1'b0);
        chk64("t1_addr_m1", a_bus_address, 64'h200);
        chk64("t1_data_m1", a_bus_write_data, 64'hBB);
        chk1("t1_we_m1", a_bus_write_enable, 1'b1);
        m1_write_enable = 1'b0;
        tick();
        chk1("t1_we_off", a_bus_write_enable, 1'b0);
        chk64("t1_addr_idle", a_bus_address, IDLE);

        // Single read on the latency-1 arbiter
        m0_read_enable = 1'b1; m0_address = 64'h80;
        tick();
        chk1("t2_grant", a_m0_grant, 1'b1);
        chk1("t2_read_strobe", a_bus_read_enable, 1'b1);
        chk64("t2_addr", a_bus_address, 64'h80);
        chk1("t2_busy1", a_busy, 1'b1);
        m0_read_enable = 1'b0;
        bus_read_data = 64'hDEADBEEF;
        tick();
        chk1("t2_busy2", a_busy, 1'b1);
        chk1("t2_strobe_off", a_bus_read_enable, 1'b0);
        chk1("t2_rv_early", a_m0_read_valid, 1'b0);
        tick();
        chk1("t2_rv", a_m0_read_valid, 1'b1);
        chk64("t2_rdata", a_m0_read_data, 64'hDEADBEEF);
        chk1("t2_busy_off", a_busy, 1'b0);
        chk64("t2_m1_rdata_untouched", a_m1_read_data, 64'd0);
        tick();
        chk1("t2_rv_pulse", a_m0_read_valid, 1'b0);
        chk64("t2_rdata_hold", a_m0_read_data, 64'hDEADBEEF);
        repeat (3) tick();

        // Write request from m1 while m0's read is outstanding
        bus_read_data = 64'h1234;
        m0_read_enable = 1'b1; m0_address = 64'h88;
        tick();
        chk1("t3_m0_grant", a_m0_grant, 1'b1);
        m0_read_enable = 1'b0;
        m1_write_enable = 1'b1; m1_address = 64'h300; m1_write_data = 64'hCC;
        tick();
        chk1("t3_no_grant_wait", a_m1_grant, 1'b0);
        tick();
        chk1("t3_rv", a_m0_read_valid, 1'b1);
        chk64("t3_rdata", a_m0_read_data, 64'h1234);
        chk1("t3_no_grant_capture", a_m1_grant, 1'b0);
        tick();
        chk1("t3_m1_grant", a_m1_grant, 1'b1);
        chk64("t3_m1_addr", a_bus_address, 64'h300);
        chk64("t3_m1_data", a_bus_write_data, 64'hCC);
        m1_write_enable = 1'b0;
        repeat (4) tick();

        // Both enables from one master: treated as a write
        m0_write_enable = 1'b1; m0_read_enable = 1'b1; m0_address = 64'h40; m0_write_data = 64'h55;
        tick();
        chk1("t6_grant", a_m0_grant, 1'b1);
        chk1("t6_we", a_bus_write_enable, 1'b1);
        chk1("t6_re", a_bus_read_enable, 1'b0);
        chk64("t6_addr", a_bus_address, 64'h40);
        chk64("t6_data", a_bus_write_data, 64'h55);
        chk1("t6_b_re", b_bus_read_enable, 1'b0);
        m0_write_enable = 1'b0; m0_read_enable = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk1("t6_no_rv_a", a_m0_read_valid, 1'b0);
            chk1("t6_no_rv_b", b_m0_read_valid, 1'b0);
            chk1("t6_not_busy", a_busy, 1'b0);
        end

        // Sustained contention: m0 was granted last, so m1 leads and they alternate
        m0_write_enable = 1'b1; m0_address = 64'h1000; m0_write_data = 64'h1;
        m1_write_enable = 1'b1; m1_address = 64'h2000; m1_write_data = 64'h2;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk1("t4_m1_turn", a_m1_grant, (c % 2) == 0);
            chk1("t4_m0_turn", a_m0_grant, (c % 2) == 1);
            m0_write_enable = ~a_m0_grant;
            m1_write_enable = ~a_m1_grant;
        end
        m0_write_enable = 1'b0; m1_write_enable = 1'b0;
        repeat (2) tick();

        // Reset in the second wait cycle of a latency-3 read
        bus_read_data = 64'h5555;
        m1_read_enable = 1'b1; m1_address = 64'h500;
        tick();
        chk1("t5_m1_grant", b_m1_grant, 1'b1);
        chk1("t5_busy1", b_busy, 1'b1);
        m1_read_enable = 1'b0;
        tick();
        chk1("t5_busy2", b_busy, 1'b1);
        reset = 1'b0;
        m0_write_enable = 1'b1; m0_address = 64'h600; m0_write_data = 64'h6;
        m1_write_enable = 1'b1; m1_address = 64'h700; m1_write_data = 64'h7;
        #1;
        chk1("t5_rst_busy", b_busy, 1'b0);
        chk64("t5_rst_addr", b_bus_address, IDLE);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk1("t5_no_rv_in_reset", b_m1_read_valid, 1'b0);
        end
        reset = 1'b1;
        tick();
        chk1("t5_m0_wins", b_m0_grant, 1'b1);
        chk1("t5_m1_waits", b_m1_grant, 1'b0);
        chk64("t5_addr", b_bus_address, 64'h600);
        m0_write_enable = 1'b0;
        tick();
        chk1("t5_m1_next", b_m1_grant, 1'b1);
        m1_write_enable = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk1("t5_no_rv_after", b_m1_read_valid, 1'b0);
        end

        // Randomized traffic with occasional resets
        for (int c = 0; c < 1500; c++) begin
            tick();
            reset           = ($urandom_range(0, 199) != 0);
            m0_write_enable = ($urandom_range(0, 3) == 0);
            m0_read_enable  = ($urandom_range(0, 2) == 0);
            m1_write_enable = ($urandom_range(0, 3) == 0);
            m1_read_enable  = ($urandom_range(0, 2) == 0);
            m0_address      = {$urandom, $urandom};
            m0_write_data   = {$urandom, $urandom};
            m1_address      = {$urandom, $urandom};
            m1_write_data   = {$urandom, $urandom};
            bus_read_data   = {$urandom, $urandom};
        end
        reset = 1'b1;
        m0_write_enable = 1'b0; m0_read_enable = 1'b0;
        m1_write_enable = 1'b0; m1_read_enable = 1'b0;
        repeat (6) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
